unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Arbiter/sequencer that shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises accesses, holds memory signals stable for a fixed multi-cycle latency, and returns read data with a one-cycle completion pulse.
- Drives per-stage stall outputs into PC write-enable / pipeline-register write logic.
- Data accesses win by default; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles memory needs per access (legal: >=1)
STARVE_MAX, 3, consecutive data wins tolerated while fetch waits (legal: >=1)

Ports:
clk_i  in  1  clock, rising edge
start_i  in  1  synchronous active-low reset (0 = reset)
if_req_i  in  1  fetch request, held until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  one-cycle fetch completion pulse
if_rdata_o  out  DATA_W  fetched instruction, valid with if_gnt_o
d_req_i  in  1  data request, held until d_done_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_done_o  out  1  one-cycle data completion pulse
d_rdata_o  out  DATA_W  load data, valid with d_done_o
mem_en_o  out  1  memory access enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data
stall_if_o  out  1  stall fetch/PC
stall_mem_o  out  1  stall MEM and upstream stages
busy_o  out  1  access in flight (state != IDLE)

Behaviour:
- Clock is clk_i. Reset is synchronous, active-low on start_i: evaluated only at a rising edge.
- Reset values: state=IDLE; all registered outputs 0, including mem_*, if_gnt_o, d_done_o, if_rdata_o, d_rdata_o; starve_cnt=0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Arbitrate on the current if_req_i and d_req_i.
  - Winner: fetch if (if_req_i & starve_cnt==STARVE_MAX); else data if d_req_i; else fetch if if_req_i; else stay IDLE.
  - On a grant, latch owner, address, we and wdata (fetch: we=0), load lat_cnt=MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_en_o=1; mem_we_o/addr/wdata come from the latched values and are stable for all MEM_LAT cycles.
  - lat_cnt decrements each cycle. At lat_cnt==0, capture mem_rdata_i and go to RESP.
- RESP:
  - Pulse if_gnt_o or d_done_o for exactly one cycle, according to owner.
  - mem_en_o=0. Go to IDLE.
- Latency: request seen in IDLE at cycle t -> mem_en_o high cycles t+1..t+MEM_LAT -> completion pulse at t+MEM_LAT+1.
- Back-to-back accesses need MEM_LAT+2 cycles each.
- Read data:
  - if_rdata_o and d_rdata_o update only on their own completed reads and otherwise hold.
  - Stores leave d_rdata_o unchanged.
- Starvation counter (width $clog2(STARVE_MAX+1)), updated at each IDLE grant:
  - Data grant while if_req_i=1: increment, saturating at STARVE_MAX.
  - Fetch grant, or if_req_i=0: clear to 0.
- Stalls (combinational):
  - stall_if_o = if_req_i & ~if_gnt_o.
  - stall_mem_o = d_req_i & ~d_done_o.
- Requester changes during an access:
  - Request dropped mid-access: the access still completes and the pulse still fires.
  - Address/data changes after the grant are ignored.
- A request still high in the cycle after its pulse is treated as a new request.
- Reset mid-access: state=IDLE and mem_en_o=0 from the next edge. The in-flight access is abandoned and no completion pulse is issued.
- No request in IDLE: mem_en_o stays 0, busy_o=0.

Test Plan:
1. Reset: hold start_i=0 for 3 cycles while both requests are high -> all outputs 0, busy_o=0, no mem_en_o.
2. Single fetch, MEM_LAT=2: if_req_i=1, if_addr_i=0x10 at cycle 0, mem_rdata_i=0xDEADBEEF -> mem_en_o=1 with addr 0x10 in cycles 1-2; if_gnt_o=1 with if_rdata_o=0xDEADBEEF in cycle 3; stall_if_o=1 in cycles 0-2, 0 in cycle 3.
3. Simultaneous requests at cycle 0 (load 0x40 -> 0x1234; fetch 0x14) -> d_done_o at cycle 3 with d_rdata_o=0x1234; fetch granted in IDLE at cycle 4; if_gnt_o at cycle 7.
4. Starvation, STARVE_MAX=2, d_req_i and if_req_i held continuously -> grants at cycles 0 and 4 go to data, grant at cycle 8 goes to fetch (if_gnt_o at cycle 11); starve_cnt then returns to 0.
5. Store: d_we_i=1, addr 0x20, wdata 0x55 -> mem_we_o=1, addr 0x20, wdata 0x55 in cycles 1-2; d_done_o at cycle 3; d_rdata_o unchanged from its prior value.
6. Reset mid-access: fetch granted at cycle 0, start_i=0 sampled at cycle 2 -> mem_en_o=0 from cycle 3, no if_gnt_o ever; a fresh request after release completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the unified memory arbiter.
// slave is the arbiter's view; master is the view of the pipeline stages and memory.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_done_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              stall_if_o;
    logic              stall_mem_o;
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rdata_o,
        output d_done_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_if_o, stall_mem_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rdata_o,
        input  d_done_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_if_o, stall_mem_o, busy_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port unified memory between fetch and load/store, holding each
// access for MEM_LAT cycles; data wins unless fetch has waited STARVE_MAX grants.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic clk_i,
    input  logic start_i,
    unified_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_TOP    = LW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              own_data;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              fetch_win;

    always_comb begin
        fetch_win = bus.if_req_i & ((starve_cnt == STARVE_TOP) | ~bus.d_req_i);
    end

    // mem_addr_o/mem_we_o/mem_wdata_o double as the latched request, so they stay
    // stable for the whole access regardless of what the requester does.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state           <= IDLE;
            own_data        <= 1'b0;
            lat_cnt         <= '0;
            starve_cnt      <= '0;
            bus.if_gnt_o    <= 1'b0;
            bus.if_rdata_o  <= '0;
            bus.d_done_o    <= 1'b0;
            bus.d_rdata_o   <= '0;
            bus.mem_en_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            bus.if_gnt_o <= 1'b0;
            bus.d_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.if_req_i | bus.d_req_i) begin
                        state        <= ACCESS;
                        lat_cnt      <= LAT_TOP;
                        bus.mem_en_o <= 1'b1;
                        if (fetch_win) begin
                            own_data        <= 1'b0;
                            bus.mem_we_o    <= 1'b0;
                            bus.mem_addr_o  <= bus.if_addr_i;
                            bus.mem_wdata_o <= '0;
                            starve_cnt      <= '0;
                        end else begin
                            own_data        <= 1'b1;
                            bus.mem_we_o    <= bus.d_we_i;
                            bus.mem_addr_o  <= bus.d_addr_i;
                            bus.mem_wdata_o <= bus.d_wdata_i;
                            if (!bus.if_req_i)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_TOP)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        state        <= RESP;
                        bus.mem_en_o <= 1'b0;
                        bus.mem_we_o <= 1'b0;
                        if (own_data) begin
                            bus.d_done_o <= 1'b1;
                            if (!bus.mem_we_o)
                                bus.d_rdata_o <= bus.mem_rdata_i;
                        end else begin
                            bus.if_gnt_o   <= 1'b1;
                            bus.if_rdata_o <= bus.mem_rdata_i;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.stall_if_o  = bus.if_req_i & ~bus.if_gnt_o;
        bus.stall_mem_o = bus.d_req_i & ~bus.d_done_o;
        bus.busy_o      = (state != IDLE);
    end
endmodule
